raycast_node_mem_slave: RTL and testbench

- Wishbone slave holding the octree node image; the responder for the raycaster core's node-fetch master.
- Serves single-word 32-bit reads (node descriptors, far-pointer words) and byte-lane writes (host image load).
- Has a programmable wait-state count to emulate external-memory latency.
- Flags bad addresses with an error response.

---
 rtl/raycast_node_mem_slave_if.sv | 22 ++
 rtl/raycast_node_mem_slave.sv | 138 +++++++++++++
 tb/tb_raycast_node_mem_slave.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/raycast_node_mem_slave_if.sv
// Wishbone classic single-word bus between the node-fetch master and the octree node memory.
interface raycast_node_mem_slave_if;
   logic [31:0] s_wb_adr_i;
   logic [31:0] s_wb_dat_i;
   logic [31:0] s_wb_dat_o;
   logic [3:0]  s_wb_sel_i;
   logic        s_wb_we_i;
   logic        s_wb_cyc_i;
   logic        s_wb_stb_i;
   logic        s_wb_ack_o;
   logic        s_wb_err_o;

   modport master (
      output s_wb_adr_i, s_wb_dat_i, s_wb_sel_i, s_wb_we_i, s_wb_cyc_i, s_wb_stb_i,
      input  s_wb_dat_o, s_wb_ack_o, s_wb_err_o
   );

   modport slave (
      input  s_wb_adr_i, s_wb_dat_i, s_wb_sel_i, s_wb_we_i, s_wb_cyc_i, s_wb_stb_i,
      output s_wb_dat_o, s_wb_ack_o, s_wb_err_o
   );
endinterface

// File: rtl/raycast_node_mem_slave.sv
// Wishbone slave holding the octree node image: 32-bit reads, byte-lane writes, error on bad address.
// Ack rises wait_states cycles after the request edge; no backpressure, a cyc drop during WAIT aborts.
module raycast_node_mem_slave #(
   parameter int mem_aw      = 10,
   parameter int wait_states = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   raycast_node_mem_slave_if.slave bus,
   output logic                    busy_o,
   output logic [15:0]             rd_count_o
);

   localparam int depth = 1 << mem_aw;
   localparam int ws_m1 = (wait_states > 0) ? wait_states - 1 : 0;

   typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_t;

   state_t              state;
   logic [3:0]          cnt;
   logic [mem_aw-1:0]   idx_q;
   logic                we_q;
   logic [3:0]          sel_q;
   logic [31:0]         dat_q;
   logic                ack_q;
   logic                err_q;
   logic [31:0]         rdat_q;
   logic [15:0]         rd_count_q;

   logic [31:0]         mem [0:depth-1];

   logic                req;
   logic                addr_bad;
   logic                take_ack;
   logic [mem_aw-1:0]   acc_idx;
   logic                acc_we;
   logic [3:0]          acc_sel;
   logic [31:0]         acc_dat;

   assign req      = bus.s_wb_cyc_i & bus.s_wb_stb_i;
   assign addr_bad = (bus.s_wb_adr_i[1:0] != 2'b00) ||
                     (bus.s_wb_adr_i[31:mem_aw+2] != '0);

   // Zero-wait accesses complete on the sampling edge itself, so they use the live bus fields.
   always_comb begin
      take_ack = 1'b0;
      acc_idx  = idx_q;
      acc_we   = we_q;
      acc_sel  = sel_q;
      acc_dat  = dat_q;
      case (state)
         IDLE: begin
            acc_idx  = bus.s_wb_adr_i[mem_aw+1:2];
            acc_we   = bus.s_wb_we_i;
            acc_sel  = bus.s_wb_sel_i;
            acc_dat  = bus.s_wb_dat_i;
            take_ack = req && !addr_bad && (wait_states == 0);
         end
         WAIT:    take_ack = bus.s_wb_cyc_i && (cnt == 4'd0);
         default: take_ack = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (take_ack && acc_we) begin
         for (int k = 0; k < 4; k++) begin
            if (acc_sel[k]) mem[acc_idx][8*k +: 8] <= acc_dat[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         idx_q      <= '0;
         we_q       <= 1'b0;
         sel_q      <= 4'd0;
         dat_q      <= 32'd0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         rdat_q     <= 32'd0;
         rd_count_q <= 16'd0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         if (take_ack) begin
            ack_q <= 1'b1;
            if (!acc_we) begin
               rdat_q <= mem[acc_idx];
               if (rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
            end
         end
         case (state)
            IDLE: begin
               if (req) begin
                  idx_q <= bus.s_wb_adr_i[mem_aw+1:2];
                  we_q  <= bus.s_wb_we_i;
                  sel_q <= bus.s_wb_sel_i;
                  dat_q <= bus.s_wb_dat_i;
                  if (addr_bad) begin
                     err_q <= 1'b1;
                     state <= ERR;
                  end else if (wait_states == 0) begin
                     state <= ACK;
                  end else begin
                     cnt   <= 4'(ws_m1);
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (!bus.s_wb_cyc_i) begin
                  state <= IDLE;
               end else if (cnt == 4'd0) begin
                  state <= ACK;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ACK:     state <= IDLE;
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.s_wb_ack_o = ack_q;
   assign bus.s_wb_err_o = err_q;
   assign bus.s_wb_dat_o = rdat_q;
   assign busy_o         = (state != IDLE);
   assign rd_count_o     = rd_count_q;

   a_ack_err_excl: assert property (@(posedge clk) disable iff (!rst) !(ack_q && err_q));
   a_ack_pulse:    assert property (@(posedge clk) disable iff (!rst) ack_q |=> !ack_q);
   a_err_pulse:    assert property (@(posedge clk) disable iff (!rst) err_q |=> !err_q);

endmodule

// File: tb/tb_raycast_node_mem_slave.sv
// Directed bench for the node memory slave with wait_states = 0, 1 and 3 instances.
module tb_raycast_node_mem_slave;

   logic        clk;
   logic        rst;
   logic [31:0] b_adr;
   logic [31:0] b_dat;
   logic [3:0]  b_sel;
   logic        b_we;
   logic        b_stb;
   logic [2:0]  cyc;

   logic [2:0]  ack_w;
   logic [2:0]  err_w;
   logic [2:0]  busy_w;
   logic [31:0] dat_w [3];
   logic [15:0] rdc_w [3];

   int checks = 0;
   int errors = 0;

   raycast_node_mem_slave_if wb0 ();
   raycast_node_mem_slave_if wb1 ();
   raycast_node_mem_slave_if wb3 ();

   assign wb0.s_wb_adr_i = b_adr;  assign wb1.s_wb_adr_i = b_adr;  assign wb3.s_wb_adr_i = b_adr;
   assign wb0.s_wb_dat_i = b_dat;  assign wb1.s_wb_dat_i = b_dat;  assign wb3.s_wb_dat_i = b_dat;
   assign wb0.s_wb_sel_i = b_sel;  assign wb1.s_wb_sel_i = b_sel;  assign wb3.s_wb_sel_i = b_sel;
   assign wb0.s_wb_we_i  = b_we;   assign wb1.s_wb_we_i  = b_we;   assign wb3.s_wb_we_i  = b_we;
   assign wb0.s_wb_stb_i = b_stb;  assign wb1.s_wb_stb_i = b_stb;  assign wb3.s_wb_stb_i = b_stb;
   assign wb0.s_wb_cyc_i = cyc[0]; assign wb1.s_wb_cyc_i = cyc[1]; assign wb3.s_wb_cyc_i = cyc[2];

   assign ack_w = {wb3.s_wb_ack_o, wb1.s_wb_ack_o, wb0.s_wb_ack_o};
   assign err_w = {wb3.s_wb_err_o, wb1.s_wb_err_o, wb0.s_wb_err_o};
   assign dat_w[0] = wb0.s_wb_dat_o;
   assign dat_w[1] = wb1.s_wb_dat_o;
   assign dat_w[2] = wb3.s_wb_dat_o;

   raycast_node_mem_slave #(.mem_aw(10), .wait_states(0)) u_ws0 (
      .clk(clk), .rst(rst), .bus(wb0), .busy_o(busy_w[0]), .rd_count_o(rdc_w[0]));
   raycast_node_mem_slave #(.mem_aw(10), .wait_states(1)) u_ws1 (
      .clk(clk), .rst(rst), .bus(wb1), .busy_o(busy_w[1]), .rd_count_o(rdc_w[1]));
   raycast_node_mem_slave #(.mem_aw(10), .wait_states(3)) u_ws3 (
      .clk(clk), .rst(rst), .bus(wb3), .busy_o(busy_w[2]), .rd_count_o(rdc_w[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // One full transaction on instance d; latency counts edges after the request edge.
   task automatic do_txn(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] s, output logic g_ack, output logic g_err,
                         output logic [31:0] g_dat, output int g_lat, output logic g_after);
      @(negedge clk);
      b_adr = a; b_dat = wd; b_sel = s; b_we = we; b_stb = 1'b1; cyc[d] = 1'b1;
      @(posedge clk); #1;
      g_lat = 0;
      while (!ack_w[d] && !err_w[d] && g_lat < 20) begin
         @(posedge clk); #1;
         g_lat++;
      end
      g_ack = ack_w[d];
      g_err = err_w[d];
      g_dat = dat_w[d];
      @(negedge clk);
      cyc[d] = 1'b0; b_stb = 1'b0; b_we = 1'b0;
      @(posedge clk); #1;
      g_after = ack_w[d] | err_w[d];
   endtask

   typedef struct {
      int          d;
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        exp_ack;
      logic        exp_err;
      logic        chk_dat;
      logic [31:0] exp_dat;
      int          exp_lat;
      logic [15:0] exp_rdc;
   } vec_t;

   vec_t vt [15];

   initial begin
      logic        g_ack, g_err, g_after;
      logic [31:0] g_dat;
      int          g_lat;

      vt[0]  = '{1, 1'b1, 32'h0000_0000, 32'h0101_0101, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,          1, 16'd0};
      vt[1]  = '{1, 1'b1, 32'h0000_0010, 32'h8003_00FF, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,          1, 16'd0};
      vt[2]  = '{1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 32'h8003_00FF, 1, 16'd1};
      vt[3]  = '{1, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,          1, 16'd1};
      vt[4]  = '{1, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 1'b1, 1'b0, 1'b0, 32'h0,          1, 16'd1};
      vt[5]  = '{1, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 32'h11BB_33DD, 1, 16'd2};
      vt[6]  = '{1, 1'b0, 32'h0000_0022, 32'h0,         4'h0, 1'b0, 1'b1, 1'b1, 32'h11BB_33DD, 0, 16'd2};
      vt[7]  = '{1, 1'b1, 32'h0000_1000, 32'h5555_5555, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0,          0, 16'd2};
      vt[8]  = '{1, 1'b0, 32'h8000_0010, 32'h0,         4'h0, 1'b0, 1'b1, 1'b1, 32'h11BB_33DD, 0, 16'd2};
      vt[9]  = '{1, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 32'h11BB_33DD, 1, 16'd3};
      vt[10] = '{1, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 32'h0101_0101, 1, 16'd4};
      vt[11] = '{0, 1'b1, 32'h0000_0100, 32'h0000_0108, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,          0, 16'd0};
      vt[12] = '{0, 1'b1, 32'h0000_010C, 32'h0C0C_0C0C, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,          0, 16'd0};
      vt[13] = '{2, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,          3, 16'd0};
      vt[14] = '{2, 1'b0, 32'h0000_0040, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 3, 16'd1};

      rst = 1'b1; cyc = 3'b000; b_stb = 1'b0; b_we = 1'b0;
      b_adr = 32'h0; b_dat = 32'h0; b_sel = 4'h0;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ack",  {31'd0, ack_w[1]},  32'd0);
      chk("reset_err",  {31'd0, err_w[1]},  32'd0);
      chk("reset_dat",  dat_w[1],           32'd0);
      chk("reset_busy", {29'd0, busy_w},    32'd0);
      chk("reset_rdc",  {16'd0, rdc_w[1]},  32'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 15; i++) begin
         do_txn(vt[i].d, vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, g_ack, g_err, g_dat, g_lat, g_after);
         chk($sformatf("v%0d_ack", i),   {31'd0, g_ack},   {31'd0, vt[i].exp_ack});
         chk($sformatf("v%0d_err", i),   {31'd0, g_err},   {31'd0, vt[i].exp_err});
         chk($sformatf("v%0d_lat", i),   g_lat,            vt[i].exp_lat);
         chk($sformatf("v%0d_pulse", i), {31'd0, g_after}, 32'd0);
         chk($sformatf("v%0d_rdc", i),   {16'd0, rdc_w[vt[i].d]}, {16'd0, vt[i].exp_rdc});
         if (vt[i].chk_dat) chk($sformatf("v%0d_dat", i), g_dat, vt[i].exp_dat);
      end

      // Node-fetch walk on the zero-wait instance: root, cyc drop, child at root+0x0C.
      do_txn(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, g_ack, g_err, g_dat, g_lat, g_after);
      chk("root_ack", {31'd0, g_ack}, 32'd1);
      chk("root_lat", g_lat, 32'd0);
      chk("root_dat", g_dat, 32'h0000_0108);
      chk("root_pulse", {31'd0, g_after}, 32'd0);
      do_txn(0, 1'b0, 32'h0000_010C, 32'h0, 4'h0, g_ack, g_err, g_dat, g_lat, g_after);
      chk("child_ack", {31'd0, g_ack}, 32'd1);
      chk("child_lat", g_lat, 32'd0);
      chk("child_dat", g_dat, 32'h0C0C_0C0C);
      chk("child_pulse", {31'd0, g_after}, 32'd0);
      chk("child_rdc", {16'd0, rdc_w[0]}, 32'd2);

      // cyc high without stb must not start a transaction.
      @(negedge clk);
      b_adr = 32'h10; cyc[1] = 1'b1; b_stb = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("nostb_busy", {31'd0, busy_w[1]}, 32'd0);
      chk("nostb_ack",  {31'd0, ack_w[1]},  32'd0);
      @(negedge clk);
      cyc[1] = 1'b0;

      // Abort a write during WAIT on the three-wait-state instance.
      @(negedge clk);
      b_adr = 32'h40; b_dat = 32'hDEAD_BEEF; b_sel = 4'hF; b_we = 1'b1; b_stb = 1'b1; cyc[2] = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy_wait", {31'd0, busy_w[2]}, 32'd1);
      @(negedge clk);
      cyc[2] = 1'b0;
      @(posedge clk); #1;
      chk("abort_busy_idle", {31'd0, busy_w[2]}, 32'd0);
      chk("abort_ack", {31'd0, ack_w[2]}, 32'd0);
      @(negedge clk);
      b_stb = 1'b0; b_we = 1'b0;
      repeat (4) @(posedge clk);
      do_txn(2, 1'b0, 32'h0000_0040, 32'h0, 4'h0, g_ack, g_err, g_dat, g_lat, g_after);
      chk("abort_readback", g_dat, 32'hCAFE_F00D);
      chk("abort_rdc", {16'd0, rdc_w[2]}, 32'd2);

      // Asynchronous reset in the WAIT state of a read, then a clean retry.
      @(negedge clk);
      b_adr = 32'h10; b_we = 1'b0; b_stb = 1'b1; cyc[1] = 1'b1;
      @(posedge clk); #1;
      chk("arst_busy_before", {31'd0, busy_w[1]}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("arst_ack",  {31'd0, ack_w[1]},  32'd0);
      chk("arst_err",  {31'd0, err_w[1]},  32'd0);
      chk("arst_busy", {31'd0, busy_w[1]}, 32'd0);
      chk("arst_rdc",  {16'd0, rdc_w[1]},  32'd0);
      @(negedge clk);
      cyc[1] = 1'b0; b_stb = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      do_txn(1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, g_ack, g_err, g_dat, g_lat, g_after);
      chk("retry_ack", {31'd0, g_ack}, 32'd1);
      chk("retry_lat", g_lat, 32'd1);
      chk("retry_dat", g_dat, 32'h8003_00FF);
      chk("retry_rdc", {16'd0, rdc_w[1]}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
